spi_slot_arbiter: RTL and testbench



---
 rtl/spi_slot_arbiter.sv | 79 +++++++
 tb/tb_spi_slot_arbiter.sv | 93 +++++++++
 2 files changed

// File: rtl/spi_slot_arbiter.sv
// spi_slot_arbiter: shares one SPIController between two requesters slot by slot,
// muxing the owner's request signals and gating timing strobes to the owner only.
module spi_slot_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       Addr15,
  output logic       Read_notWrite,
  output logic       Addr,
  output logic       Data,
  input  logic       ShiftAddr,
  input  logic       ShiftDataRead,
  input  logic       ShiftDataWrite,
  input  logic       PresetCarry,
  input  logic       EndOfPhase,
  input  logic       PrepOutput,
  input  logic       req0,
  input  logic       req1,
  input  logic       r0_Addr15,
  input  logic       r0_Read_notWrite,
  input  logic       r0_Addr,
  input  logic       r0_Data,
  input  logic       r1_Addr15,
  input  logic       r1_Read_notWrite,
  input  logic       r1_Addr,
  input  logic       r1_Data,
  output logic       r0_ShiftAddr,
  output logic       r0_ShiftDataRead,
  output logic       r0_ShiftDataWrite,
  output logic       r0_PresetCarry,
  output logic       r0_EndOfPhase,
  output logic       r0_PrepOutput,
  output logic       r1_ShiftAddr,
  output logic       r1_ShiftDataRead,
  output logic       r1_ShiftDataWrite,
  output logic       r1_PresetCarry,
  output logic       r1_EndOfPhase,
  output logic       r1_PrepOutput,
  output logic [1:0] gnt,
  output logic [3:0] burst
);
  logic [1:0] r_gnt, w_gnt;
  logic [3:0] r_burst, w_burst;
  logic       w_take1;
  always_comb begin
    w_take1 = req1 & ~(req0 & (r_burst >= 4'(MAX_BURST)));
    w_gnt   = w_take1 ? 2'b10 : req0 ? 2'b01 : req1 ? 2'b10 : 2'b00;
    w_burst = w_gnt[1] ? ((r_burst == 4'hf) ? r_burst : r_burst + 4'd1) : 4'd0;
  end
  // EndOfPhase of the finishing slot is still gated by the outgoing gnt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt   <= 2'b01;
      r_burst <= 4'd0;
    end else if (EndOfPhase) begin
      r_gnt   <= w_gnt;
      r_burst <= w_burst;
    end
  end
  assign gnt   = r_gnt;
  assign burst = r_burst;
  assign Addr15        = r_gnt[1] ? r1_Addr15        : r_gnt[0] ? r0_Addr15        : 1'b0;
  assign Read_notWrite = r_gnt[1] ? r1_Read_notWrite : r_gnt[0] ? r0_Read_notWrite : 1'b1;
  assign Addr          = r_gnt[1] ? r1_Addr          : r_gnt[0] ? r0_Addr          : 1'b0;
  assign Data          = r_gnt[1] ? r1_Data          : r_gnt[0] ? r0_Data          : 1'b0;
  assign r0_ShiftAddr      = ShiftAddr      & r_gnt[0];
  assign r0_ShiftDataRead  = ShiftDataRead  & r_gnt[0];
  assign r0_ShiftDataWrite = ShiftDataWrite & r_gnt[0];
  assign r0_PresetCarry    = PresetCarry    & r_gnt[0];
  assign r0_EndOfPhase     = EndOfPhase     & r_gnt[0];
  assign r0_PrepOutput     = PrepOutput     & r_gnt[0];
  assign r1_ShiftAddr      = ShiftAddr      & r_gnt[1];
  assign r1_ShiftDataRead  = ShiftDataRead  & r_gnt[1];
  assign r1_ShiftDataWrite = ShiftDataWrite & r_gnt[1];
  assign r1_PresetCarry    = PresetCarry    & r_gnt[1];
  assign r1_EndOfPhase     = EndOfPhase     & r_gnt[1];
  assign r1_PrepOutput     = PrepOutput     & r_gnt[1];
endmodule

// File: tb/tb_spi_slot_arbiter.sv
// tb_spi_slot_arbiter: random and directed slot traffic checked against a
// behavioural arbitration model.
module tb_spi_slot_arbiter;
  localparam int MAX_B = 4;
  logic       clk = 1'b0;
  logic       rst, req0, req1;
  logic [5:0] s, o0, o1;
  logic [3:0] q0, q1, spi;
  logic [1:0] gnt;
  logic [3:0] burst;
  int         n_chk = 0, n_err = 0;
  int         mg, mb;
  always #5 clk = ~clk;
  spi_slot_arbiter #(.MAX_BURST(MAX_B)) dut (
    .clk(clk), .rst(rst),
    .Addr15(spi[3]), .Read_notWrite(spi[2]), .Addr(spi[1]), .Data(spi[0]),
    .ShiftAddr(s[0]), .ShiftDataRead(s[1]), .ShiftDataWrite(s[2]),
    .PresetCarry(s[3]), .EndOfPhase(s[4]), .PrepOutput(s[5]),
    .req0(req0), .req1(req1),
    .r0_Addr15(q0[3]), .r0_Read_notWrite(q0[2]), .r0_Addr(q0[1]), .r0_Data(q0[0]),
    .r1_Addr15(q1[3]), .r1_Read_notWrite(q1[2]), .r1_Addr(q1[1]), .r1_Data(q1[0]),
    .r0_ShiftAddr(o0[0]), .r0_ShiftDataRead(o0[1]), .r0_ShiftDataWrite(o0[2]),
    .r0_PresetCarry(o0[3]), .r0_EndOfPhase(o0[4]), .r0_PrepOutput(o0[5]),
    .r1_ShiftAddr(o1[0]), .r1_ShiftDataRead(o1[1]), .r1_ShiftDataWrite(o1[2]),
    .r1_PresetCarry(o1[3]), .r1_EndOfPhase(o1[4]), .r1_PrepOutput(o1[5]),
    .gnt(gnt), .burst(burst)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic a, input logic b, input logic e);
    int exp_spi;
    @(negedge clk);
    rst = r; req0 = a; req1 = b;
    s = 6'($urandom); s[4] = e;
    q0 = 4'($urandom); q1 = 4'($urandom);
    #1;
    exp_spi = (mg == 2) ? int'(q1) : (mg == 1) ? int'(q0) : 4'b0100;
    chk("gnt", int'(gnt), mg);
    chk("burst", int'(burst), mb);
    chk("spi_mux", int'(spi), exp_spi);
    chk("strobe_r0", int'(o0), (mg == 1) ? int'(s) : 0);
    chk("strobe_r1", int'(o1), (mg == 2) ? int'(s) : 0);
    if (r) begin
      mg = 1; mb = 0;
    end else if (e) begin
      if (b && !(a && mb >= MAX_B)) begin
        mg = 2; mb = (mb < 15) ? mb + 1 : 15;
      end else if (a) begin
        mg = 1; mb = 0;
      end else begin
        mg = 0; mb = 0;
      end
    end
  endtask
  initial begin
    int seq [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; s = '0; q0 = '0; q1 = '0;
    mg = 1; mb = 0;
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("reset_gnt", int'(gnt), 1);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("starve_seq", int'(gnt), seq[k]);
      for (int c = 2; c < 84; c++) step(1'b0, 1'b1, 1'b1, 1'b0);
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("r1_only_gnt", int'(gnt), 2);
    end
    chk("burst_sat", int'(burst), 15);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_gnt", int'(gnt), 0);
    chk("idle_spi", int'(spi), 4'b0100);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_mid_gnt", int'(gnt), 1);
    chk("rst_mid_burst", int'(burst), 0);
    for (int c = 0; c < 4000; c++)
      step($urandom_range(199) == 0, 1'($urandom), 1'($urandom), $urandom_range(5) == 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
